pause_access_ctl: RTL and testbench
===================================

PAUSE_ACCESS_CTL -- requirements
Module: pause_access_ctl

Purpose: initiator side of the pause handshake. Drives pause_request into the pause block, waits for pause_cpu, then grants a client (e.g. hiscore save/load) exclusive access to CPU-side RAM while the CPU is frozen.

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16: cycles pause_cpu must be held high before grant.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum cycles to wait for pause_cpu after requesting.
REQ-003 SHALL have parameter COOLDOWN_CYCLES, default 64: minimum idle cycles between released access and the next request.
REQ-004 SHALL have port clk_sys  input  1  core system clock, the same clock as the pause block.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port access_req  input  1  client wants access; level, held until access_done.
REQ-007 SHALL have port access_done  input  1  client finished; single-cycle pulse, valid only while access_grant=1.
REQ-008 SHALL have port pause_cpu  input  1  registered pause status returned by the pause block.
REQ-009 SHALL have port pause_request  output  1  registered request to the pause block.
REQ-010 SHALL have port access_grant  output  1  registered; client may touch CPU RAM.
REQ-011 SHALL have port busy  output  1  high in any state except IDLE.
REQ-012 SHALL have port timeout_err  output  1  single-cycle pulse on pause-acknowledge timeout.
REQ-013 SHALL have port abort_err  output  1  single-cycle pulse when pause is lost during grant.

Function
REQ-014 SHALL implement the states IDLE, REQ, SETTLE, GRANT, RELEASE and COOLDOWN.
REQ-015 IDLE: on access_req=1, the block SHALL set pause_request=1 on the next edge and enter REQ.
REQ-016 REQ: the block SHALL load the wait counter with 0 on entry and increment it each cycle; on pause_cpu=1 it SHALL enter SETTLE.
REQ-017 REQ: if the counter reaches TIMEOUT_CYCLES-1 with pause_cpu=0, the block SHALL pulse timeout_err, drop pause_request and enter COOLDOWN.
REQ-018 SETTLE: the block SHALL count consecutive pause_cpu=1 cycles, starting at 0 on entry; pause_cpu=0 SHALL restart the count; at SETTLE_CYCLES-1 it SHALL set access_grant=1 and enter GRANT.
REQ-019 If pause_cpu is already 1 when access_req arrives (user pause active), the block SHALL still pass through REQ and the full SETTLE; there is no bypass.
REQ-020 GRANT: on access_done=1, the block SHALL clear access_grant and pause_request on the same edge and enter RELEASE.
REQ-021 GRANT: if pause_cpu=0 is sampled, the block SHALL clear access_grant and pause_request, pulse abort_err and enter COOLDOWN; this takes priority over a simultaneous access_done.
REQ-022 RELEASE SHALL last exactly 1 cycle and then enter COOLDOWN; the block SHALL NOT wait for pause_cpu to fall, because a user pause may hold it high.
REQ-023 COOLDOWN SHALL last COOLDOWN_CYCLES cycles and then enter IDLE; access_req is ignored in COOLDOWN.
REQ-024 If access_req drops before grant, in REQ or SETTLE, the block SHALL drop pause_request and enter COOLDOWN without any error pulse.
REQ-025 access_done outside GRANT SHALL be ignored.
REQ-026 Grant latency from access_req rising, with pause_cpu following pause_request by 1 cycle: access_grant SHALL be 1 exactly 2+SETTLE_CYCLES edges after access_req rises (18 at default).
REQ-027 The shared counter SHALL be $clog2 of the largest parameter plus 1 bits wide, SHALL saturate and never wrap, and SHALL be cleared on every state entry.
REQ-028 All outputs SHALL be driven from registers, with no combinational path from inputs.

Reset
REQ-029 On reset=1 at an edge, the block SHALL enter IDLE and drive pause_request=0, access_grant=0, busy=0, timeout_err=0, abort_err=0, with the counter at 0.
REQ-030 Reset mid-GRANT SHALL drop access_grant on the same edge with no abort_err pulse.
REQ-031 After reset, the next access_req SHALL be serviced without a cooldown.

Structure
REQ-032 The state encoding and the default SETTLE, TIMEOUT and COOLDOWN constants SHALL live in the shared package pause_pkg, alongside the pause option index constants.
REQ-033 The block SHALL be one module with no sub-modules; one counter SHALL be shared by the REQ, SETTLE and COOLDOWN states.

Verification
REQ-034 Nominal: the bench SHALL raise access_req with a model that drives pause_cpu = pause_request delayed 1 cycle -> access_grant high 18 edges later; access_done then clears grant and request on the next edge; busy falls 65 cycles after that.
REQ-035 Timeout: the bench SHALL hold pause_cpu=0 -> a single timeout_err pulse 1024 cycles after REQ entry, pause_request=0, and no grant ever.
REQ-036 Settle glitch: the bench SHALL drop pause_cpu for 1 cycle at settle count 10 -> the count restarts and the grant is delayed by 11 cycles.
REQ-037 Abort: the bench SHALL drop pause_cpu in GRANT in the same cycle as access_done -> abort_err pulses, grant drops, and the block goes straight to COOLDOWN with no RELEASE.
REQ-038 User pause: with pause_cpu held high throughout -> grant arrives after REQ plus 16 settle cycles; after access_done the block returns to IDLE while pause_cpu stays 1.
REQ-039 Reset mid-GRANT: the bench SHALL assert reset for 1 cycle -> all outputs 0 next edge, no error pulse, and a new access_req is accepted immediately.

Source files
------------

// File: rtl/pause_pkg.sv
// Shared definitions for the pause subsystem: access-controller state encoding,
// default timing constants and pause option indices.
package pause_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_GRANT    = 3'd3,
        ST_RELEASE  = 3'd4,
        ST_COOLDOWN = 3'd5
    } pac_state_t;

    localparam int DEF_SETTLE_CYCLES   = 16;
    localparam int DEF_TIMEOUT_CYCLES  = 1024;
    localparam int DEF_COOLDOWN_CYCLES = 64;

    // Bit positions inside the pause option word
    localparam int PAUSE_OPT_DIM     = 0;
    localparam int PAUSE_OPT_OSD     = 1;
    localparam int PAUSE_OPT_HISCORE = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pause_access_ctl.sv
// Initiator side of the pause handshake: requests a CPU pause, waits for it to
// settle, then grants a client exclusive access to CPU-side RAM.
module pause_access_ctl
    import pause_pkg::*;
#(
    parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic access_req,
    input  logic access_done,
    input  logic pause_cpu,
    output logic pause_request,
    output logic access_grant,
    output logic busy,
    output logic timeout_err,
    output logic abort_err
);

    localparam int CNT_W = $clog2(max3(SETTLE_CYCLES, TIMEOUT_CYCLES, COOLDOWN_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOLDOWN_LAST = CNT_W'(COOLDOWN_CYCLES - 1);

    pac_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
    logic             pause_request_reg, pause_request_next;
    logic             access_grant_reg, access_grant_next;
    logic             busy_reg, busy_next;
    logic             timeout_err_reg, timeout_err_next;
    logic             abort_err_reg, abort_err_next;

    // Saturating increment; the counter never wraps back to zero
    assign cnt_inc = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg         <= ST_IDLE;
            cnt_reg           <= '0;
            pause_request_reg <= 1'b0;
            access_grant_reg  <= 1'b0;
            busy_reg          <= 1'b0;
            timeout_err_reg   <= 1'b0;
            abort_err_reg     <= 1'b0;
        end else begin
            state_reg         <= state_next;
            cnt_reg           <= cnt_next;
            pause_request_reg <= pause_request_next;
            access_grant_reg  <= access_grant_next;
            busy_reg          <= busy_next;
            timeout_err_reg   <= timeout_err_next;
            abort_err_reg     <= abort_err_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        cnt_next           = cnt_reg;
        pause_request_next = pause_request_reg;
        access_grant_next  = access_grant_reg;
        timeout_err_next   = 1'b0;
        abort_err_next     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (access_req) begin
                    state_next         = ST_REQ;
                    pause_request_next = 1'b1;
                end
            end
            ST_REQ: begin
                if (!access_req) begin
                    state_next         = ST_COOLDOWN;
                    pause_request_next = 1'b0;
                    cnt_next           = '0;
                end else if (pause_cpu) begin
                    state_next = ST_SETTLE;
                    cnt_next   = '0;
                end else if (cnt_reg >= TIMEOUT_LAST) begin
                    state_next         = ST_COOLDOWN;
                    pause_request_next = 1'b0;
                    timeout_err_next   = 1'b1;
                    cnt_next           = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            ST_SETTLE: begin
                // The acknowledge seen in REQ counts as the first settled cycle
                if (!access_req) begin
                    state_next         = ST_COOLDOWN;
                    pause_request_next = 1'b0;
                    cnt_next           = '0;
                end else if (!pause_cpu) begin
                    cnt_next = '0;
                end else if (cnt_inc >= SETTLE_LAST) begin
                    state_next        = ST_GRANT;
                    access_grant_next = 1'b1;
                    cnt_next          = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            ST_GRANT: begin
                // Losing the pause outranks a simultaneous access_done
                if (!pause_cpu) begin
                    state_next         = ST_COOLDOWN;
                    access_grant_next  = 1'b0;
                    pause_request_next = 1'b0;
                    abort_err_next     = 1'b1;
                    cnt_next           = '0;
                end else if (access_done) begin
                    state_next         = ST_RELEASE;
                    access_grant_next  = 1'b0;
                    pause_request_next = 1'b0;
                    cnt_next           = '0;
                end
            end
            ST_RELEASE: begin
                state_next = ST_COOLDOWN;
                cnt_next   = '0;
            end
            ST_COOLDOWN: begin
                if (cnt_reg >= COOLDOWN_LAST) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next         = ST_IDLE;
                cnt_next           = '0;
                pause_request_next = 1'b0;
                access_grant_next  = 1'b0;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    assign pause_request = pause_request_reg;
    assign access_grant  = access_grant_reg;
    assign busy          = busy_reg;
    assign timeout_err   = timeout_err_reg;
    assign abort_err     = abort_err_reg;

endmodule

// File: tb/tb_pause_access_ctl.sv
// Scoreboard bench for pause_access_ctl: stimulus queues expected output changes,
// a monitor compares each observed change against the queue head.
module tb_pause_access_ctl;

    logic clk_sys = 1'b0;
    logic reset = 1'b1;
    logic access_req = 1'b0;
    logic access_done = 1'b0;
    logic pause_cpu;
    logic pause_request, access_grant, busy, timeout_err, abort_err;

    // Pause block model: acknowledge follows the request by one cycle
    logic pause_cpu_q = 1'b0;
    logic cut = 1'b0;
    logic hold_low = 1'b0;
    logic user_pause = 1'b0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic [4:0] prev_out;

    typedef struct {
        int         cyc;
        logic [4:0] val;
        string      name;
    } exp_t;
    exp_t exp_q[$];

    pause_access_ctl dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .access_req    (access_req),
        .access_done   (access_done),
        .pause_cpu     (pause_cpu),
        .pause_request (pause_request),
        .access_grant  (access_grant),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .abort_err     (abort_err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        cyc <= cyc + 1;
        pause_cpu_q <= pause_request;
    end

    assign pause_cpu = user_pause | (pause_cpu_q & ~cut & ~hold_low);

    // Vector layout: {pause_request, access_grant, busy, timeout_err, abort_err}
    always @(negedge clk_sys) begin
        logic [4:0] cur;
        exp_t e;
        if (mon_en) begin
            cur = {pause_request, access_grant, busy, timeout_err, abort_err};
            if (cur !== prev_out) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got=%b want=none", cyc, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.val !== cur) begin
                        errors++;
                        $display("FAIL %s got cyc=%0d out=%b want cyc=%0d out=%b",
                                 e.name, cyc, cur, e.cyc, e.val);
                    end else begin
                        $display("ok   %s cyc=%0d out=%b", e.name, cyc, cur);
                    end
                end
            end
            prev_out = cur;
        end
    end

    function automatic void push_exp(input int c, input logic [4:0] v, input string n);
        exp_t e;
        e.cyc = c;
        e.val = v;
        e.name = n;
        exp_q.push_back(e);
    endfunction

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk_sys);
    endtask

    task automatic drain_check(input string n);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending got=%0d events want=0 (next %s at cyc %0d)",
                     n, exp_q.size(), exp_q[0].name, exp_q[0].cyc);
            exp_q.delete();
        end else begin
            $display("ok   %s all events seen", n);
        end
    endtask

    initial begin
        int s;
        int d;
        logic [4:0] rst_out;

        // Reset state
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        rst_out = {pause_request, access_grant, busy, timeout_err, abort_err};
        checks++;
        if (rst_out !== 5'b00000) begin
            errors++;
            $display("FAIL reset_state got=%b want=00000", rst_out);
        end else begin
            $display("ok   reset_state out=%b", rst_out);
        end
        reset = 1'b0;
        prev_out = rst_out;
        mon_en = 1'b1;
        wait_to(cyc + 2);

        // Nominal grant, then a request raised during cooldown, granted and aborted
        s = cyc;
        d = s + 21;
        push_exp(s + 1,   5'b10100, "nom_req");
        push_exp(s + 18,  5'b11100, "nom_grant");
        push_exp(d,       5'b00100, "nom_release");
        push_exp(d + 65,  5'b00000, "nom_idle");
        push_exp(d + 66,  5'b10100, "cd_req_after_idle");
        push_exp(d + 83,  5'b11100, "cd_grant");
        push_exp(d + 86,  5'b00101, "abort_pulse");
        push_exp(d + 87,  5'b00100, "abort_clear");
        push_exp(d + 150, 5'b00000, "abort_idle");
        access_req = 1'b1;
        wait_to(s + 20);
        access_done = 1'b1;
        wait_to(d);
        access_done = 1'b0;
        access_req = 1'b0;
        wait_to(d + 10);
        access_req = 1'b1;
        wait_to(d + 85);
        access_done = 1'b1;
        cut = 1'b1;
        wait_to(d + 86);
        access_done = 1'b0;
        cut = 1'b0;
        access_req = 1'b0;
        wait_to(d + 153);
        drain_check("nominal_abort");

        // Acknowledge timeout
        s = cyc;
        hold_low = 1'b1;
        push_exp(s + 1,    5'b10100, "to_req");
        push_exp(s + 1025, 5'b00110, "to_pulse");
        push_exp(s + 1026, 5'b00100, "to_clear");
        push_exp(s + 1089, 5'b00000, "to_idle");
        access_req = 1'b1;
        wait_to(s + 1026);
        access_req = 1'b0;
        wait_to(s + 1092);
        hold_low = 1'b0;
        drain_check("timeout");

        // One-cycle acknowledge glitch at settle count 10
        s = cyc;
        push_exp(s + 1,  5'b10100, "gl_req");
        push_exp(s + 29, 5'b11100, "gl_grant");
        push_exp(s + 31, 5'b00100, "gl_release");
        push_exp(s + 96, 5'b00000, "gl_idle");
        access_req = 1'b1;
        wait_to(s + 13);
        cut = 1'b1;
        wait_to(s + 14);
        cut = 1'b0;
        wait_to(s + 30);
        access_done = 1'b1;
        wait_to(s + 31);
        access_done = 1'b0;
        access_req = 1'b0;
        wait_to(s + 99);
        drain_check("glitch");

        // Request withdrawn during settle
        s = cyc;
        push_exp(s + 1,  5'b10100, "wd_req");
        push_exp(s + 6,  5'b00100, "wd_drop");
        push_exp(s + 70, 5'b00000, "wd_idle");
        access_req = 1'b1;
        wait_to(s + 5);
        access_req = 1'b0;
        wait_to(s + 73);
        drain_check("withdraw");

        // User pause already active; stray access_done in SETTLE is ignored
        user_pause = 1'b1;
        wait_to(cyc + 2);
        s = cyc;
        push_exp(s + 1,  5'b10100, "up_req");
        push_exp(s + 17, 5'b11100, "up_grant");
        push_exp(s + 20, 5'b00100, "up_release");
        push_exp(s + 85, 5'b00000, "up_idle");
        access_req = 1'b1;
        wait_to(s + 5);
        access_done = 1'b1;
        wait_to(s + 6);
        access_done = 1'b0;
        wait_to(s + 19);
        access_done = 1'b1;
        wait_to(s + 20);
        access_done = 1'b0;
        access_req = 1'b0;
        wait_to(s + 88);
        user_pause = 1'b0;
        wait_to(cyc + 3);
        drain_check("user_pause");

        // Reset during grant, then immediate re-service with no cooldown
        s = cyc;
        push_exp(s + 1,  5'b10100, "rg_req");
        push_exp(s + 18, 5'b11100, "rg_grant");
        push_exp(s + 21, 5'b00000, "rg_reset");
        push_exp(s + 22, 5'b10100, "rg_req2");
        push_exp(s + 39, 5'b11100, "rg_grant2");
        push_exp(s + 42, 5'b00100, "rg_release2");
        push_exp(s + 107, 5'b00000, "rg_idle2");
        access_req = 1'b1;
        wait_to(s + 20);
        reset = 1'b1;
        wait_to(s + 21);
        reset = 1'b0;
        wait_to(s + 41);
        access_done = 1'b1;
        wait_to(s + 42);
        access_done = 1'b0;
        access_req = 1'b0;
        wait_to(s + 110);
        drain_check("reset_grant");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
